// File: rtl/vec4_bram_writer_pkg.sv
// Shared constants and types for the 4-lane vector BRAM datapath.
// The read port model and the matrix blocks use the same definitions.
package vec4_bram_writer_pkg;

  localparam int LANES      = 4;
  localparam int WORD_W     = 32;
  localparam int BYTE_SHIFT = 2;
  localparam int LANE_W     = $clog2(LANES);

  typedef logic [LANE_W-1:0] lane_t;

  localparam lane_t LAST_LANE = lane_t'(LANES - 1);

  typedef enum logic {
    IDLE,
    WRITE
  } wr_state_e;

endpackage

// File: rtl/vec4_bram_writer_if.sv
// Request bus carrying one 4-word vector and its per-lane mask.
// The master side is the matrix-load/result-store logic, and the slave side is the writer.
interface vec4_bram_writer_if
  import vec4_bram_writer_pkg::*;
#(
  parameter int DATA_W = WORD_W
) ();

  logic              wr_valid;
  logic              wr_ready;
  logic [31:0]       wr_addr;
  logic [DATA_W-1:0] wr_data0;
  logic [DATA_W-1:0] wr_data1;
  logic [DATA_W-1:0] wr_data2;
  logic [DATA_W-1:0] wr_data3;
  logic [LANES-1:0]  wr_mask;

  modport master (
    output wr_valid, wr_addr, wr_data0, wr_data1, wr_data2, wr_data3, wr_mask,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data0, wr_data1, wr_data2, wr_data3, wr_mask,
    output wr_ready
  );

endinterface

// File: rtl/vec4_bram_writer.sv
// Serialises one accepted 4-word vector into four single-word BRAM writes
// at consecutive word indices, addressed exactly like the 4-word read port.
module vec4_bram_writer
  import vec4_bram_writer_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  vec4_bram_writer_if.slave wr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done
);

  wr_state_e         state;
  lane_t             lane;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] data_q [LANES];
  logic [LANES-1:0]  mask_q;

  logic              accept;
  logic              last;
  lane_t             lane_nxt;
  logic [ADDR_W-1:0] req_base;

  assign accept   = wr.wr_valid && wr.wr_ready;
  assign last     = (state == WRITE) && (lane == LAST_LANE);
  assign lane_nxt = lane + lane_t'(1);
  assign req_base = wr.wr_addr[ADDR_W+BYTE_SHIFT-1:BYTE_SHIFT];

  // Byte-offset bits and the address bits beyond the BRAM depth are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr.wr_addr[31:ADDR_W+BYTE_SHIFT], wr.wr_addr[BYTE_SHIFT-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lane        <= '0;
      base        <= '0;
      // NOTE: the capture registers are reset too, so an aborted request leaves no stale vector behind.
      data_q      <= '{default: '0};
      mask_q      <= '0;
      wr.wr_ready <= 1'b1;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // NOTE: all state is updated with non-blocking assignments so every branch sees the pre-edge values.
      done <= last;

      if (accept) begin
        // Lane 0 goes out on the acceptance edge. The BRAM samples it one edge later.
        state       <= WRITE;
        lane        <= '0;
        base        <= req_base;
        data_q[0]   <= wr.wr_data0;
        data_q[1]   <= wr.wr_data1;
        data_q[2]   <= wr.wr_data2;
        data_q[3]   <= wr.wr_data3;
        mask_q      <= wr.wr_mask;
        wr.wr_ready <= 1'b0;
        busy        <= 1'b1;
        mem_we      <= wr.wr_mask[0];
        mem_addr    <= req_base;
        mem_wdata   <= wr.wr_data0;
      end else if (last) begin
        state       <= IDLE;
        lane        <= '0;
        wr.wr_ready <= 1'b1;
        busy        <= 1'b0;
        mem_we      <= 1'b0;
      end else if (state == WRITE) begin
        // Masked lanes still advance the address and data, so occupancy stays fixed at four cycles.
        lane        <= lane_nxt;
        mem_addr    <= base + ADDR_W'(lane_nxt);
        mem_wdata   <= data_q[lane_nxt];
        mem_we      <= mask_q[lane_nxt];
        wr.wr_ready <= (lane_nxt == LAST_LANE);
      end
    end
  end

endmodule

// File: tb/tb_vec4_bram_writer.sv
// Directed bench for vec4_bram_writer with a BRAM model and a 4-word read-port model.
module tb_vec4_bram_writer;

  logic        clk;
  logic        rst_n;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;

  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int we_cnt   = 0;

  logic [31:0] mem [32];

  vec4_bram_writer_if #(.DATA_W(32)) wr_bus ();

  vec4_bram_writer #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr        (wr_bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (done)   done_cnt = done_cnt + 1;
    if (mem_we) we_cnt   = we_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a, input int l);
    logic [4:0] i;
    i = 5'(a >> 2) + 5'(l);
    return mem[i];
  endfunction

  task automatic drive_req(input logic [31:0] a, input logic [3:0][31:0] d, input logic [3:0] m);
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_addr  = a;
    wr_bus.wr_data0 = d[0];
    wr_bus.wr_data1 = d[1];
    wr_bus.wr_data2 = d[2];
    wr_bus.wr_data3 = d[3];
    wr_bus.wr_mask  = m;
  endtask

  typedef struct {
    logic [31:0]      addr;
    logic [3:0][31:0] d;
    logic [3:0]       mask;
    logic [3:0][4:0]  idx;
    logic [3:0]       we;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [31:0] snap [4];
    int          d0;
    int          w0;
    logic [3:0][31:0] da;
    logic [3:0][31:0] db;

    vecs[0] = '{addr: 32'h00, d: {32'h41500000, 32'h41100000, 32'h40A00000, 32'h3F800000},
                mask: 4'hF, idx: {5'd3, 5'd2, 5'd1, 5'd0}, we: 4'b1111};
    vecs[1] = '{addr: 32'h20, d: {32'h4444000B, 32'h3333000A, 32'h22220009, 32'h11110008},
                mask: 4'hA, idx: {5'd11, 5'd10, 5'd9, 5'd8}, we: 4'b1010};
    vecs[2] = '{addr: 32'h7C, d: {32'h88880002, 32'h77770001, 32'h66660000, 32'h5555001F},
                mask: 4'hF, idx: {5'd2, 5'd1, 5'd0, 5'd31}, we: 4'b1111};
    vecs[3] = '{addr: 32'h7F, d: {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000, 32'h9999001F},
                mask: 4'hF, idx: {5'd2, 5'd1, 5'd0, 5'd31}, we: 4'b1111};
    vecs[4] = '{addr: 32'h44, d: {32'h12340014, 32'h12340013, 32'h12340012, 32'h12340011},
                mask: 4'h1, idx: {5'd20, 5'd19, 5'd18, 5'd17}, we: 4'b0001};
    vecs[5] = '{addr: 32'h30, d: {32'hFFFF000F, 32'hFFFF000E, 32'hFFFF000D, 32'hFFFF000C},
                mask: 4'h0, idx: {5'd15, 5'd14, 5'd13, 5'd12}, we: 4'b0000};

    for (int i = 0; i < 32; i++) mem[i] = 32'hDEAD0000 | 32'(i);

    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_addr  = '0;
    wr_bus.wr_data0 = '0;
    wr_bus.wr_data1 = '0;
    wr_bus.wr_data2 = '0;
    wr_bus.wr_data3 = '0;
    wr_bus.wr_mask  = '0;
    rst_n = 1'b0;
    #12;
    check("rst_ready", 32'(wr_bus.wr_ready), 32'd1);
    check("rst_we",    32'(mem_we),          32'd0);
    check("rst_addr",  32'(mem_addr),        32'd0);
    check("rst_wdata", mem_wdata,            32'd0);
    check("rst_busy",  32'(busy),            32'd0);
    check("rst_done",  32'(done),            32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single requests from the table
    for (int v = 0; v < 6; v++) begin
      for (int l = 0; l < 4; l++) snap[l] = rd(vecs[v].addr, l);
      w0 = we_cnt;
      drive_req(vecs[v].addr, vecs[v].d, vecs[v].mask);
      @(posedge clk);
      #1 wr_bus.wr_valid = 1'b0;
      for (int l = 0; l < 4; l++) begin
        @(negedge clk);
        check($sformatf("v%0d_l%0d_we", v, l),    32'(mem_we),          32'(vecs[v].we[l]));
        check($sformatf("v%0d_l%0d_addr", v, l),  32'(mem_addr),        32'(vecs[v].idx[l]));
        check($sformatf("v%0d_l%0d_wdata", v, l), mem_wdata,            vecs[v].d[l]);
        check($sformatf("v%0d_l%0d_busy", v, l),  32'(busy),            32'd1);
        check($sformatf("v%0d_l%0d_ready", v, l), 32'(wr_bus.wr_ready), (l == 3) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      check($sformatf("v%0d_done", v),      32'(done),            32'd1);
      check($sformatf("v%0d_idle_busy", v), 32'(busy),            32'd0);
      check($sformatf("v%0d_idle_we", v),   32'(mem_we),          32'd0);
      check($sformatf("v%0d_idle_rdy", v),  32'(wr_bus.wr_ready), 32'd1);
      @(negedge clk);
      check($sformatf("v%0d_done_low", v), 32'(done), 32'd0);
      check($sformatf("v%0d_we_cnt", v), 32'(we_cnt - w0), 32'($countones(vecs[v].we)));
      for (int l = 0; l < 4; l++)
        check($sformatf("v%0d_rd%0d", v, l), rd(vecs[v].addr, l), vecs[v].we[l] ? vecs[v].d[l] : snap[l]);
    end

    // Back-to-back: the second request waits on the bus until the lane-3 cycle
    da = {32'h41500000, 32'h41100000, 32'h40A00000, 32'h3F800000};
    db = {32'h41600000, 32'h41200000, 32'h40C00000, 32'h40000000};
    d0 = done_cnt;
    w0 = we_cnt;
    @(negedge clk);
    drive_req(32'h00, da, 4'hF);
    @(posedge clk);
    #1 drive_req(32'h10, db, 4'hF);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("b2b_%0d_we", i),    32'(mem_we),   32'd1);
      check($sformatf("b2b_%0d_addr", i),  32'(mem_addr), 32'(i));
      check($sformatf("b2b_%0d_wdata", i), mem_wdata,     (i < 4) ? da[i % 4] : db[i % 4]);
      check($sformatf("b2b_%0d_ready", i), 32'(wr_bus.wr_ready), (i % 4 == 3) ? 32'd1 : 32'd0);
      check($sformatf("b2b_%0d_done", i),  32'(done),     (i == 4) ? 32'd1 : 32'd0);
      if (i == 3) begin
        @(posedge clk);
        #1 wr_bus.wr_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_done2", 32'(done), 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    check("b2b_done_cnt", 32'(done_cnt - d0), 32'd2);
    check("b2b_we_cnt",   32'(we_cnt - w0),   32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("b2b_rd%0d", i), rd(32'h00, i), (i < 4) ? da[i % 4] : db[i % 4]);

    // wr_valid toggling with junk while lanes 0..2 are in flight
    da = {32'h5A5A001B, 32'h5A5A001A, 32'h5A5A0019, 32'h5A5A0018};
    db = {32'hBADBAD03, 32'hBADBAD02, 32'hBADBAD01, 32'hBADBAD00};
    w0 = we_cnt;
    d0 = done_cnt;
    @(negedge clk);
    drive_req(32'h60, da, 4'hF);
    @(posedge clk);
    #1 drive_req(32'h00, db, 4'hF);
    wr_bus.wr_valid = 1'b0;
    for (int l = 0; l < 4; l++) begin
      @(negedge clk);
      check($sformatf("ign_l%0d_addr", l),  32'(mem_addr), 32'(24 + l));
      check($sformatf("ign_l%0d_wdata", l), mem_wdata,     da[l]);
      wr_bus.wr_valid = (l == 0 || l == 2);
    end
    @(negedge clk);
    check("ign_done", 32'(done), 32'd1);
    check("ign_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("ign_no_restart_busy", 32'(busy),   32'd0);
    check("ign_no_restart_we",   32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    check("ign_we_cnt",   32'(we_cnt - w0),   32'd4);
    check("ign_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("ign_mem0",     rd(32'h00, 0),      32'h3F800000);
    for (int l = 0; l < 4; l++) check($sformatf("ign_rd%0d", l), rd(32'h60, l), da[l]);

    // Asynchronous reset after the second lane has been written
    da = {32'h77770017, 32'h77770016, 32'h77770015, 32'h77770014};
    for (int l = 0; l < 4; l++) snap[l] = rd(32'h50, l);
    w0 = we_cnt;
    d0 = done_cnt;
    @(negedge clk);
    drive_req(32'h50, da, 4'hF);
    @(posedge clk);
    #1 wr_bus.wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rsm_l1_addr", 32'(mem_addr), 32'd21);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rsm_we",    32'(mem_we),          32'd0);
    check("rsm_addr",  32'(mem_addr),        32'd0);
    check("rsm_wdata", mem_wdata,            32'd0);
    check("rsm_busy",  32'(busy),            32'd0);
    check("rsm_done",  32'(done),            32'd0);
    check("rsm_ready", 32'(wr_bus.wr_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rsm_post_ready", 32'(wr_bus.wr_ready), 32'd1);
    @(posedge clk);
    #1;
    check("rsm_we_cnt",   32'(we_cnt - w0),   32'd2);
    check("rsm_done_cnt", 32'(done_cnt - d0), 32'd0);
    check("rsm_rd0", rd(32'h50, 0), da[0]);
    check("rsm_rd1", rd(32'h50, 1), da[1]);
    check("rsm_rd2", rd(32'h50, 2), snap[2]);
    check("rsm_rd3", rd(32'h50, 3), snap[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vec4_bram_writer.md
Name: vec4_bram_writer

Overview:
- Write-side counterpart to the combinational 4-word BRAM read port used by the matrix/vector datapath.
- Accepts one 4-word vector (e.g. one matrix column of IEEE-754 singles) per handshake, byte-addressed exactly as the read side: word index = addr >> 2.
- Serialises the vector into four single-word BRAM writes at consecutive word indices, so data written here is read back unchanged through read0..read3 at the same addr.
- Sits between the matrix-load/result-store logic and the single-port BRAM write interface.

Parameters:
- ADDR_W, 5, width of BRAM word index; covers depth 32, enough for one 4x4 matrix plus spare.
- DATA_W, 32, word width; IEEE-754 single.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  request valid.
- wr_ready  out  1  block can accept a request this cycle.
- wr_addr  in  32  byte address of lane 0; bits [1:0] ignored.
- wr_data0  in  DATA_W  lane 0 word, written at word index (wr_addr>>2)+0.
- wr_data1  in  DATA_W  lane 1 word, written at index +1.
- wr_data2  in  DATA_W  lane 2 word, written at index +2.
- wr_data3  in  DATA_W  lane 3 word, written at index +3.
- wr_mask  in  4  per-lane write enable; bit i gates lane i.
- mem_we  out  1  BRAM write strobe.
- mem_addr  out  ADDR_W  BRAM word index.
- mem_wdata  out  DATA_W  BRAM write data.
- busy  out  1  a request is in progress.
- done  out  1  one-cycle pulse, vector fully written.

Behaviour:
- One clock; reset is asynchronous and active-low. All state changes on the rising edge of clk.
- Reset values: state=IDLE, lane=0, wr_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0. Captured data and mask are cleared to 0.
- States:
  - IDLE: wr_ready=1. On wr_valid&&wr_ready, capture the following and go to WRITE:
    - base = wr_addr[ADDR_W+1:2]
    - wr_data0..3
    - wr_mask
    - lane=0
  - WRITE: one lane per cycle, registered outputs.
    - mem_addr = base+lane, truncated mod 2^ADDR_W (wraps; no error).
    - mem_wdata = data[lane].
    - mem_we = mask[lane].
    - lane increments each cycle.
  - Last lane (lane==3):
    - wr_ready=1.
    - If a new request is accepted that cycle, recapture and restart at lane 0 with no bubble.
    - Otherwise return to IDLE.
- Latency: the request accepted at edge N produces memory writes at edges N+1..N+4. done is high for the cycle after the lane-3 write (edge N+5), including when a back-to-back request is accepted.
- Write timing: mem_* are registered and valid in cycles N+1..N+4. The BRAM samples them on the following edge, so outputs must stay stable for the whole cycle.
- Masked-off lanes:
  - Still consume their cycle, giving fixed 4-cycle occupancy.
  - mem_we=0; mem_addr and mem_wdata still advance.
  - A mask of 4'b0000 still completes and pulses done.
- busy=1 in WRITE, 0 in IDLE.
- mem_we=0 in IDLE.
- Inputs are ignored when wr_ready=0; the requester must hold them while valid&&!ready.
- Reset mid-operation: asynchronously aborts the request. Lanes already written stay in memory, remaining lanes are not written, and no done pulse occurs.
- Wrap example: addr=0x7C with ADDR_W=5 gives indices 31, 0, 1, 2.

Decomposition:
- Shared package, also used by the read port model and later matrix blocks:
  - LANES=4
  - WORD_W=32
  - state enum {IDLE, WRITE}
  - byte-to-word shift constant 2
- No sub-module is needed; the lane select is a 4:1 mux inline.
- Optional: the 4:1 mux may be factored as vec4_lane_mux if reused by a future streaming reader.

Test Plan:
- Write 1.0/5.0/9.0/13.0 (0x3F800000, 0x40A00000, 0x41100000, 0x41500000) at addr 0x0, mask 4'hF -> mem_we on 4 consecutive cycles at indices 0, 1, 2, 3 with those words; done 1 cycle later; read port at addr 0 returns the same four words.
- Back-to-back: second request (addr 0x10, 2.0/6.0/10.0/14.0) held valid during the lane-3 cycle -> accepted with no bubble; 8 consecutive mem_we cycles at indices 0..7; two done pulses.
- Mask 4'b1010 at addr 0x20 -> mem_we only for indices 9 and 11; indices 8 and 10 unchanged; occupancy still 4 cycles; done pulses.
- Wrap: addr 0x7C, ADDR_W=5 -> writes at indices 31, 0, 1, 2; addr low bits 0x7F give the same result.
- rst_n asserted after the second lane write -> outputs go to reset values immediately; only indices base and base+1 are written; no done; wr_ready=1 after release.
- wr_valid toggled while busy (not the last lane) -> ignored; no capture, no extra writes.
